// File: rtl/cordic_if.sv
// Sample/result handshake bundle for cordic_pipe: valid/ready input side with
// mode, x/y/z and tag, and valid/ready output side with full-precision results.
interface cordic_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    mode_in;
    logic signed [WIDTH-1:0] x_in;
    logic signed [WIDTH-1:0] y_in;
    logic signed [WIDTH-1:0] z_in;
    logic [TAG_W-1:0]        tag_in;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH+1:0] x_out;
    logic signed [WIDTH+1:0] y_out;
    logic signed [WIDTH-1:0] z_out;
    logic [TAG_W-1:0]        tag_out;

    modport master (
        output in_valid, mode_in, x_in, y_in, z_in, tag_in, out_ready,
        input  in_ready, out_valid, x_out, y_out, z_out, tag_out
    );

    modport slave (
        input  in_valid, mode_in, x_in, y_in, z_in, tag_in, out_ready,
        output in_ready, out_valid, x_out, y_out, z_out, tag_out
    );
endinterface

// File: rtl/cordic_pipe.sv
// Fully pipelined signed CORDIC, one iteration per stage, rotation/vectoring per sample.
// Optional CORDIC_GAIN_COMP_EN adds a K^-1 output stage (latency STAGES+1).
module cordic_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 14,
    parameter int TAG_W  = 4
) (
    input  logic     clk,
    input  logic     rst,
    cordic_if.slave  bus
);
    localparam int XW = WIDTH + 2;

    // atan(2^-i) scaled so that 2^31 == pi
    function automatic logic [31:0] atan32(input int i);
        case (i)
            0:       return 32'h20000000;
            1:       return 32'h12E4051E;
            2:       return 32'h09FB385B;
            3:       return 32'h051111D4;
            4:       return 32'h028B0D43;
            5:       return 32'h0145D7E1;
            6:       return 32'h00A2F61E;
            7:       return 32'h00517C55;
            8:       return 32'h0028BE53;
            9:       return 32'h00145F2F;
            10:      return 32'h000A2F98;
            11:      return 32'h000517CC;
            12:      return 32'h00028BE6;
            13:      return 32'h000145F3;
            14:      return 32'h0000A2FA;
            15:      return 32'h0000517D;
            16:      return 32'h000028BE;
            17:      return 32'h0000145F;
            18:      return 32'h00000A30;
            19:      return 32'h00000518;
            20:      return 32'h0000028C;
            21:      return 32'h00000146;
            22:      return 32'h000000A3;
            default: return 32'h00000051;
        endcase
    endfunction

    function automatic logic signed [WIDTH-1:0] round_atan(input int i);
        logic [32:0] t;
        t = {1'b0, atan32(i)};
        if (WIDTH < 32)
            t = t + (33'd1 << (31 - WIDTH));
        return WIDTH'(t >> (32 - WIDTH));
    endfunction

    logic adv;
    logic out_vld;

    logic                    vld_p [STAGES];
    logic                    m_p   [STAGES];
    logic [TAG_W-1:0]        t_p   [STAGES];
    logic signed [XW-1:0]    x_p   [STAGES];
    logic signed [XW-1:0]    y_p   [STAGES];
    logic signed [WIDTH-1:0] z_p   [STAGES];

    assign adv          = ~out_vld | bus.out_ready;
    assign bus.in_ready = adv;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        localparam logic signed [WIDTH-1:0] ATAN = round_atan(i);

        logic                    v_s, m_s, d;
        logic [TAG_W-1:0]        t_s;
        logic signed [XW-1:0]    x_s, y_s;
        logic signed [WIDTH-1:0] z_s;

        if (i == 0) begin : g_src
            assign v_s = bus.in_valid;
            assign m_s = bus.mode_in;
            assign t_s = bus.tag_in;
            assign x_s = {{2{bus.x_in[WIDTH-1]}}, bus.x_in};
            assign y_s = {{2{bus.y_in[WIDTH-1]}}, bus.y_in};
            assign z_s = bus.z_in;
        end else begin : g_src
            assign v_s = vld_p[i-1];
            assign m_s = m_p[i-1];
            assign t_s = t_p[i-1];
            assign x_s = x_p[i-1];
            assign y_s = y_p[i-1];
            assign z_s = z_p[i-1];
        end

        // d = 1 selects the +1 rotation direction
        assign d = m_s ? y_s[XW-1] : ~z_s[WIDTH-1];

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_p[i] <= 1'b0;
                m_p[i]   <= 1'b0;
                t_p[i]   <= '0;
                x_p[i]   <= '0;
                y_p[i]   <= '0;
                z_p[i]   <= '0;
            end else if (adv) begin
                vld_p[i] <= v_s;
                m_p[i]   <= m_s;
                t_p[i]   <= t_s;
                if (d) begin
                    x_p[i] <= x_s - (y_s >>> i);
                    y_p[i] <= y_s + (x_s >>> i);
                    z_p[i] <= z_s - ATAN;
                end else begin
                    x_p[i] <= x_s + (y_s >>> i);
                    y_p[i] <= y_s - (x_s >>> i);
                    z_p[i] <= z_s + ATAN;
                end
            end
        end
    end

`ifdef CORDIC_GAIN_COMP_EN
    localparam logic signed [16:0] KINV = 17'sd19898;

    function automatic logic signed [XW-1:0] gain_comp(input logic signed [XW-1:0] v);
        logic signed [XW+16:0] p;
        p = v * KINV;
        return XW'(p >>> 15);
    endfunction

    logic                    vld_g;
    logic [TAG_W-1:0]        t_g;
    logic signed [XW-1:0]    x_g, y_g;
    logic signed [WIDTH-1:0] z_g;

    // gain compensation stage
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_g <= 1'b0;
            t_g   <= '0;
            x_g   <= '0;
            y_g   <= '0;
            z_g   <= '0;
        end else if (adv) begin
            vld_g <= vld_p[STAGES-1];
            t_g   <= t_p[STAGES-1];
            x_g   <= gain_comp(x_p[STAGES-1]);
            y_g   <= gain_comp(y_p[STAGES-1]);
            z_g   <= z_p[STAGES-1];
        end
    end

    assign out_vld     = vld_g;
    assign bus.x_out   = x_g;
    assign bus.y_out   = y_g;
    assign bus.z_out   = z_g;
    assign bus.tag_out = t_g;
`else
    assign out_vld     = vld_p[STAGES-1];
    assign bus.x_out   = x_p[STAGES-1];
    assign bus.y_out   = y_p[STAGES-1];
    assign bus.z_out   = z_p[STAGES-1];
    assign bus.tag_out = t_p[STAGES-1];
`endif

    assign bus.out_valid = out_vld;
endmodule

// File: tb/tb_cordic_pipe.sv
// Directed bench for cordic_pipe: reset, single vectors with latency, stream,
// output stall and mid-stream reset, each against hand-computed expectations.
module tb_cordic_pipe;
    localparam int WIDTH  = 16;
    localparam int STAGES = 14;
    localparam int TAG_W  = 4;
    localparam int TOL_XY = STAGES;
    localparam int TOL_Z  = 4;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT = STAGES + 1;
    localparam bit GC  = 1'b1;
`else
    localparam int LAT = STAGES;
    localparam bit GC  = 1'b0;
`endif

    typedef struct {
        logic mode;
        int   x, y, z;
        int   ex, ey, ez;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    vec_t tv [6];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    cordic_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    cordic_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input longint obs, input longint exp, input longint tol);
        longint diff;
        n_cmp++;
        diff = obs - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    // unit-gain expectations when the output stage removes the CORDIC gain
    function automatic longint exp_g(input int e);
        longint p;
        p = longint'(e) * 19898;
        return GC ? (p >>> 15) : longint'(e);
    endfunction

    task automatic set_in(input int k, input logic [TAG_W-1:0] t);
        bus.in_valid = 1'b1;
        bus.mode_in  = tv[k].mode;
        bus.x_in     = WIDTH'(tv[k].x);
        bus.y_in     = WIDTH'(tv[k].y);
        bus.z_in     = WIDTH'(tv[k].z);
        bus.tag_in   = t;
    endtask

    task automatic chk_out(input string nm, input int k, input logic [TAG_W-1:0] t);
        chk({nm, "_x"}, bus.x_out, exp_g(tv[k].ex), TOL_XY);
        chk({nm, "_y"}, bus.y_out, exp_g(tv[k].ey), TOL_XY);
        chk({nm, "_z"}, bus.z_out, tv[k].ez, TOL_Z);
        chk({nm, "_tag"}, bus.tag_out, t, 0);
    endtask

    task automatic single(input string nm, input int k, input logic [TAG_W-1:0] t);
        int lat;
        @(posedge clk); #1;
        set_in(k, t);
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk({nm, "_rdy_idle"}, bus.in_ready, 1, 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < LAT + 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_lat"}, lat, LAT, 0);
        @(negedge clk);
        chk_out(nm, k, t);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk({nm, "_drained"}, bus.out_valid, 0, 0);
    endtask

    task automatic run_stream(input string nm, input int n, input int stall_after);
        int   k = 0, m = 0, last = -1, cyc = 0, stall_left = 0, extra = 0;
        bit   stall_done = 1'b0, first = 1'b0;
        logic signed [WIDTH+1:0] sx, sy;
        logic signed [WIDTH-1:0] sz;
        logic [TAG_W-1:0] st;
        bus.out_ready = 1'b1;
        while (m < n && cyc < n + LAT + 40) begin
            @(posedge clk); #1;
            cyc++;
            if (k < n) set_in(k % 6, TAG_W'(k));
            else       bus.in_valid = 1'b0;
            if (stall_after >= 0 && !stall_done && m == stall_after && bus.out_valid) begin
                stall_left = 5;
                stall_done = 1'b1;
                first      = 1'b1;
            end
            bus.out_ready = (stall_left == 0);
            @(negedge clk);
            if (stall_left > 0) begin
                chk({nm, "_stall_rdy"}, bus.in_ready, 0, 0);
                chk({nm, "_stall_vld"}, bus.out_valid, 1, 0);
                if (first) begin
                    sx = bus.x_out; sy = bus.y_out; sz = bus.z_out; st = bus.tag_out;
                    first = 1'b0;
                end else begin
                    chk({nm, "_hold_x"}, bus.x_out, sx, 0);
                    chk({nm, "_hold_y"}, bus.y_out, sy, 0);
                    chk({nm, "_hold_z"}, bus.z_out, sz, 0);
                    chk({nm, "_hold_tag"}, bus.tag_out, st, 0);
                end
                stall_left--;
            end
            if (bus.out_valid && bus.out_ready) begin
                chk_out($sformatf("%s%0d", nm, m), m % 6, TAG_W'(m));
                if (stall_after < 0 && last >= 0)
                    chk({nm, "_gap"}, cyc - last, 1, 0);
                last = cyc;
                m++;
            end
            if (bus.in_valid && bus.in_ready) k++;
        end
        chk({nm, "_count"}, m, n, 0);
        bus.in_valid = 1'b0;
        repeat (LAT + 2) begin
            @(negedge clk);
            if (bus.out_valid) extra++;
        end
        chk({nm, "_extra"}, extra, 0, 0);
    endtask

    initial begin
        tv[0] = '{1'b0, 10000,      0,  16384,     0,  16468,     0};
        tv[1] = '{1'b0, 10000,      0,  -8192, 11645, -11645,     0};
        tv[2] = '{1'b1, 10000,  10000,      0, 23289,      0,  8192};
        tv[3] = '{1'b1, 10000, -10000,      0, 23289,      0, -8192};
        tv[4] = '{1'b0, 10000,      0,   8192, 11645,  11645,     0};
        tv[5] = '{1'b0,     0,  10000,      0,     0,  16468,     0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.mode_in   = 1'b0;
        bus.x_in      = '0;
        bus.y_in      = '0;
        bus.z_in      = '0;
        bus.tag_in    = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_vld", bus.out_valid, 0, 0);
        chk("rst_x", bus.x_out, 0, 0);
        chk("rst_y", bus.y_out, 0, 0);
        chk("rst_z", bus.z_out, 0, 0);
        chk("rst_tag", bus.tag_out, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rdy_after_rst", bus.in_ready, 1, 0);

        single("rot90", 0, 4'h3);
        single("rotm45", 1, 4'h5);
        single("vec45", 2, 4'hA);

        run_stream("bb", 32, -1);
        run_stream("st", 12, 3);

        // mid-stream reset with 7 samples in flight
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            set_in(i % 6, TAG_W'(i));
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_x", bus.x_out, 0, 0);
        begin
            int seen = 0;
            repeat (LAT + 5) begin
                @(negedge clk);
                if (bus.out_valid) seen++;
            end
            chk("mrst_quiet", seen, 0, 0);
        end
        single("post_rst", 3, 4'h7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cordic_pipe.md
# cordic_pipe

Parametrised, fully pipelined signed CORDIC engine. It is the generalised successor to the fixed-shift single-iteration stages: one iteration per pipeline stage, with shift amount and arctangent constant per stage index. Each sample selects rotation or vectoring mode, and valid/ready flow control runs end to end. It sits between the sample front end and the phase/magnitude consumers and replaces hand-chained per-shift stage instances.

## Interface
Parameters:
- WIDTH, 16: input sample width for x/y/z, two's complement; legal range 8..32.
- STAGES, 14: number of iterations (pipeline stages); legal range 1..min(WIDTH,24).
- TAG_W, 4: width of the user sideband carried alongside each sample.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample present.
- in_ready  out  1  pipeline accepts the sample this cycle.
- mode_in  in  1  0 = rotation (drive z to 0), 1 = vectoring (drive y to 0).
- x_in, y_in  in  WIDTH  signed vector components.
- z_in  in  WIDTH  signed binary angle; 2^(WIDTH-1) represents pi.
- tag_in  in  TAG_W  sideband, passed through untouched.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- x_out, y_out  out  WIDTH+2  signed results, full internal precision.
- z_out  out  WIDTH  signed residual angle.
- tag_out  out  TAG_W  sideband aligned with the result.

## Operation
- Internal x/y width is WIDTH+2: inputs are sign-extended, giving 2 guard bits for the gain of about 1.6468 and the sqrt(2) growth.
- z is WIDTH bits with wrap-around arithmetic.
- Stage i, for i = 0..STAGES-1, registers mode, tag, valid, x, y and z.
- Direction d is +1 in these cases:
  - rotation mode, when z >= 0 (signed compare);
  - vectoring mode, when y < 0.
- In all other cases d is -1.
- Stage update, using arithmetic (sign-preserving) shifts >>> i:
  - x' = x - d*(y >>> i)
  - y' = y + d*(x >>> i)
  - z' = z - d*atan_i
- atan_i = round(atan(2^-i) * 2^(WIDTH-1)/pi).
- atan_i comes from a 24-entry constant table held at 32-bit precision and rounded to WIDTH bits at elaboration. Reference entries:
  - entry 0 = 0x20000000
  - entry 1 = 0x12E4051E
  - entry 2 = 0x09FB385B
- Convergence domain:
  - rotation requires |z_in| <= 2^(WIDTH-2) (pi/2);
  - vectoring requires x_in >= 0.
- Outside that domain, results are unspecified but no X values propagate.
- Flow control uses a global advance signal, adv = !out_valid | out_ready.
  - When adv = 1, every stage register loads from its predecessor, and stage 0 loads the input with valid = in_valid.
  - When adv = 0, every stage register holds.
- in_ready = adv, combinationally. A sample transfers when in_valid & in_ready.
- Bubbles are not collapsed: empty stages advance like full ones.
- Outputs hold stable while out_valid & !out_ready.

## Timing
- Latency is STAGES cycles from input transfer to out_valid, provided no stall occurs.
- Throughput is 1 sample per clock while out_ready = 1.
- Reset, on the first rising edge with rst = 1:
  - all valid bits clear;
  - x_out, y_out, z_out, tag_out = 0;
  - out_valid = 0;
  - in_ready = 1 from the cycle after reset deasserts.
- Reset mid-operation discards every in-flight sample. No output appears for any sample accepted before reset.
- When out_valid = 1 and out_ready = 0 in the same cycle that in_valid = 1: in_ready = 0, and the input is not taken.
- out_ready is ignored while out_valid = 0.

## Configuration
- CORDIC_GAIN_COMP_EN defined:
  - adds one output stage that multiplies x and y by K^-1 = 19898/32768 (Q1.15), using arithmetic shift right by 15 and truncation;
  - latency becomes STAGES+1;
  - z and tag are delayed one cycle to stay aligned;
  - the stage obeys the same adv stall rule.
- CORDIC_GAIN_COMP_EN undefined:
  - x_out and y_out carry the raw CORDIC gain of about 1.6468;
  - latency is STAGES.

## Test plan
All values below use WIDTH=16, STAGES=14, no gain compensation, tolerance ±STAGES LSB on x/y and ±4 LSB on z.
- Rotation at +pi/2: x_in=10000, y_in=0, z_in=16384, mode=0 -> after 14 cycles, x_out≈0, y_out≈16468, z_out≈0.
- Rotation at -pi/4: x_in=10000, y_in=0, z_in=-8192 -> x_out≈11645, y_out≈-11645.
- Vectoring: x_in=10000, y_in=10000, mode=1, tag=0xA -> x_out≈23289, y_out≈0, z_out≈8192, tag_out=0xA.
- Back-to-back stream of 32 samples with mixed modes and out_ready=1 -> 32 results on consecutive cycles, in order, tags preserved.
- Stall: hold out_ready=0 for 5 cycles with a result pending -> in_ready=0 and outputs stable; after release, no sample is lost or duplicated.
- Reset mid-stream: rst pulsed with 7 samples in flight -> out_valid stays 0 until new inputs complete their latency. With CORDIC_GAIN_COMP_EN, the first vector case gives x_out≈14142 at latency 15.
